// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall/flush controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes, with Mealy outputs and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead_In,
  input  logic [4:0]       ID_EX_Rt_In,
  input  logic [4:0]       IF_ID_Rs_In,
  input  logic [4:0]       IF_ID_Rt_In,
  input  logic             Branch_Taken_In,
  input  logic             Mem_Busy_In,
  input  logic             Stall_Clr_In,
  output logic             PCWrite_Out,
  output logic             IF_IDWrite_Out,
  output logic             ID_EX_Bubble_Out,
  output logic             IF_Flush_Out,
  output logic [CNT_W-1:0] Stall_Count_Out
);

  typedef enum logic [1:0] {RUN, LU_HOLD, MEM_WAIT, FLUSH} state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_CYC - 1);

  state_t           r_state, w_state_next;
  logic [2:0]       r_lu_cnt, w_lu_cnt_next;
  logic [1:0]       r_fl_cnt, w_fl_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;
  logic             w_pcw, w_ifid, w_bubble, w_flush;

  assign w_lu = ID_EX_MemRead_In && (ID_EX_Rt_In != 5'd0) &&
                ((ID_EX_Rt_In == IF_ID_Rs_In) || (ID_EX_Rt_In == IF_ID_Rt_In));

  always_comb begin
    w_state_next  = r_state;
    w_lu_cnt_next = r_lu_cnt;
    w_fl_cnt_next = r_fl_cnt;
    w_pcw         = 1'b0;
    w_ifid        = 1'b0;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    // A memory freeze wins in every state and discards any pending lu/flush work.
    if (Mem_Busy_In) begin
      w_pcw         = 1'b1;
      w_ifid        = 1'b1;
      w_state_next  = MEM_WAIT;
      w_lu_cnt_next = 3'd0;
      w_fl_cnt_next = 2'd0;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          w_state_next = RUN;
          if (Branch_Taken_In) begin
            w_flush = 1'b1;
            if (FL_INIT != 2'd0) begin
              w_state_next  = FLUSH;
              w_fl_cnt_next = FL_INIT;
            end
          end else if (w_lu) begin
            w_pcw    = 1'b1;
            w_ifid   = 1'b1;
            w_bubble = 1'b1;
            if (LU_INIT != 3'd0) begin
              w_state_next  = LU_HOLD;
              w_lu_cnt_next = LU_INIT;
            end
          end
        end
        LU_HOLD: begin
          w_pcw    = 1'b1;
          w_ifid   = 1'b1;
          w_bubble = 1'b1;
          if (r_lu_cnt <= 3'd1) begin
            w_state_next  = RUN;
            w_lu_cnt_next = 3'd0;
          end else begin
            w_lu_cnt_next = r_lu_cnt - 3'd1;
          end
        end
        FLUSH: begin
          w_flush = 1'b1;
          if (r_fl_cnt <= 2'd1) begin
            w_state_next  = RUN;
            w_fl_cnt_next = 2'd0;
          end else begin
            w_fl_cnt_next = r_fl_cnt - 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_lu_cnt <= 3'd0;
      r_fl_cnt <= 2'd0;
    end else begin
      r_state  <= w_state_next;
      r_lu_cnt <= w_lu_cnt_next;
      r_fl_cnt <= w_fl_cnt_next;
    end
  end

  // Outputs are gated by reset so the pipe runs normally while reset is held.
  assign PCWrite_Out      = reset & w_pcw;
  assign IF_IDWrite_Out   = reset & w_ifid;
  assign ID_EX_Bubble_Out = reset & w_bubble;
  assign IF_Flush_Out     = reset & w_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (Stall_Clr_In) begin
      r_stall_cnt <= '0;
    end else if (PCWrite_Out && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign Stall_Count_Out = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two differently parameterised instances on shared inputs,
// directed scenarios followed by random cycles, checked against a pending-work model.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       mem_read = 1'b0;
  logic [4:0] ld_rt = '0, id_rs = '0, id_rt = '0;
  logic       br = 1'b0, busy = 1'b0, clr = 1'b0;

  logic        pcw_a, ifid_a, bub_a, fl_a;
  logic [3:0]  cnt_a;
  logic        pcw_b, ifid_b, bub_b, fl_b;
  logic [15:0] cnt_b;

  hazard_stall_ctrl #(.LU_CYCLES(3), .FLUSH_CYC(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .ID_EX_MemRead_In(mem_read), .ID_EX_Rt_In(ld_rt),
    .IF_ID_Rs_In(id_rs), .IF_ID_Rt_In(id_rt), .Branch_Taken_In(br), .Mem_Busy_In(busy),
    .Stall_Clr_In(clr), .PCWrite_Out(pcw_a), .IF_IDWrite_Out(ifid_a),
    .ID_EX_Bubble_Out(bub_a), .IF_Flush_Out(fl_a), .Stall_Count_Out(cnt_a));

  hazard_stall_ctrl #(.LU_CYCLES(1), .FLUSH_CYC(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .ID_EX_MemRead_In(mem_read), .ID_EX_Rt_In(ld_rt),
    .IF_ID_Rs_In(id_rs), .IF_ID_Rt_In(id_rt), .Branch_Taken_In(br), .Mem_Busy_In(busy),
    .Stall_Clr_In(clr), .PCWrite_Out(pcw_b), .IF_IDWrite_Out(ifid_b),
    .ID_EX_Bubble_Out(bub_b), .IF_Flush_Out(fl_b), .Stall_Count_Out(cnt_b));

  int n_cmp = 0;
  int n_err = 0;

  // Model: remaining forced stall / flush cycles, plus the expected counter value.
  int m_lu[2]  = '{0, 0};
  int m_fl[2]  = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int p_lc[2]  = '{3, 1};
  int p_fc[2]  = '{2, 1};
  int p_max[2] = '{15, 65535};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag, bit mr, logic [4:0] lrt, logic [4:0] rs, logic [4:0] rt,
                     bit b, bit mb, bit c, bit rst_n);
    bit lu;
    bit e_pcw[2], e_ifid[2], e_bub[2], e_fl[2];
    mem_read = mr; ld_rt = lrt; id_rs = rs; id_rt = rt;
    br = b; busy = mb; clr = c; reset = rst_n;
    @(negedge clk);
    lu = mr && (lrt != 0) && (lrt == rs || lrt == rt);
    for (int i = 0; i < 2; i++) begin
      e_pcw[i] = 0; e_ifid[i] = 0; e_bub[i] = 0; e_fl[i] = 0;
      if (!rst_n) begin
        m_lu[i] = 0; m_fl[i] = 0; m_cnt[i] = 0;
      end else if (mb) begin
        e_pcw[i] = 1; e_ifid[i] = 1;
        m_lu[i] = 0; m_fl[i] = 0;
      end else if (m_lu[i] > 0) begin
        e_pcw[i] = 1; e_ifid[i] = 1; e_bub[i] = 1;
        m_lu[i]--;
      end else if (m_fl[i] > 0) begin
        e_fl[i] = 1;
        m_fl[i]--;
      end else if (b) begin
        e_fl[i] = 1;
        m_fl[i] = p_fc[i] - 1;
      end else if (lu) begin
        e_pcw[i] = 1; e_ifid[i] = 1; e_bub[i] = 1;
        m_lu[i] = p_lc[i] - 1;
      end
    end
    check($sformatf("%s/a.pcw", tag),  32'(pcw_a),  32'(e_pcw[0]));
    check($sformatf("%s/a.ifid", tag), 32'(ifid_a), 32'(e_ifid[0]));
    check($sformatf("%s/a.bub", tag),  32'(bub_a),  32'(e_bub[0]));
    check($sformatf("%s/a.fl", tag),   32'(fl_a),   32'(e_fl[0]));
    check($sformatf("%s/a.cnt", tag),  32'(cnt_a),  32'(m_cnt[0]));
    check($sformatf("%s/b.pcw", tag),  32'(pcw_b),  32'(e_pcw[1]));
    check($sformatf("%s/b.ifid", tag), 32'(ifid_b), 32'(e_ifid[1]));
    check($sformatf("%s/b.bub", tag),  32'(bub_b),  32'(e_bub[1]));
    check($sformatf("%s/b.fl", tag),   32'(fl_b),   32'(e_fl[1]));
    check($sformatf("%s/b.cnt", tag),  32'(cnt_b),  32'(m_cnt[1]));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || c) m_cnt[i] = 0;
      else if (e_pcw[i] && m_cnt[i] < p_max[i]) m_cnt[i]++;
    end
    #1;
  endtask

  initial begin
    // Reset held: everything must read zero
    cyc("rst0", 1, 5, 5, 0, 1, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 1);

    // Load r5, ID rs=5
    cyc("lu_rs", 1, 5, 5, 9, 0, 0, 0, 1);
    cyc("lu_rs+1", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("lu_rs+2", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("lu_rs+3", 0, 0, 0, 0, 0, 0, 1, 1);

    // Load into $0 is never a hazard
    cyc("lu_r0", 1, 0, 0, 0, 0, 0, 0, 1);
    cyc("lu_r0+1", 0, 0, 0, 0, 0, 0, 0, 1);

    // rt match, MemRead drops after first cycle
    cyc("lu_rt", 1, 7, 1, 7, 0, 0, 0, 1);
    cyc("lu_rt+1", 0, 7, 1, 7, 0, 0, 0, 1);
    cyc("lu_rt+2", 0, 7, 1, 7, 0, 0, 0, 1);
    cyc("lu_rt+3", 0, 7, 1, 7, 0, 0, 0, 1);

    // Branch with a simultaneous load-use: branch wins
    cyc("br", 1, 3, 3, 3, 1, 0, 0, 1);
    cyc("br+1", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("br+2", 0, 0, 0, 0, 0, 0, 0, 1);

    // Memory wait in LU_HOLD discards the remaining lu stall
    cyc("lu_mw", 1, 4, 4, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc($sformatf("mw%0d", k), 1, 4, 4, 0, 1, 1, 0, 1);
    cyc("mw_end", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("mw_end+1", 0, 0, 0, 0, 0, 0, 0, 1);

    // Memory wait released straight into a branch
    cyc("mw_br0", 0, 0, 0, 0, 1, 1, 0, 1);
    cyc("mw_br1", 0, 0, 0, 0, 1, 0, 0, 1);
    cyc("mw_br2", 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset pulse inside MEM_WAIT
    cyc("rmw0", 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("rmw1", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("rmw2", 0, 0, 0, 0, 0, 0, 0, 1);

    // Saturation of the 4-bit counter, then clear
    for (int k = 0; k < 20; k++) cyc($sformatf("sat%0d", k), 0, 0, 0, 0, 0, 1, 0, 1);
    check("sat_a_const", 32'(cnt_a), 32'd15);
    check("sat_b_const", 32'(cnt_b), 32'd20);
    cyc("clr", 0, 0, 0, 0, 0, 1, 1, 1);
    check("clr_a_const", 32'(cnt_a), 32'd0);
    cyc("clr+1", 0, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic; small register numbers make matches frequent
    for (int k = 0; k < 3000; k++) begin
      cyc($sformatf("rnd%0d", k),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 150) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
